// File: rtl/cylinder_cache_ctl.sv
`default_nettype none
// ============================================================================
// Module   : cylinder_cache_ctl
// Brief    : Cylinder buffer for the Hawk drive emulator. Random-access byte
//            port for the drive side, plus a storage-side engine that
//            bulk-loads a cylinder and flushes only dirty sectors as a
//            tagged byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module cylinder_cache_ctl #(
   parameter int HEADS     = 4,
   parameter int SECTORS   = 16,
   parameter int SEC_BYTES = 402,
   parameter int BYTE_W    = 9,
   localparam int HW = $clog2(HEADS),
   localparam int SW = $clog2(SECTORS),
   localparam int AW = HW + SW + BYTE_W
) (
   input  logic          clk,
   input  logic          rst_n,
   // drive-side random-access port
   input  logic [AW-1:0] a_addr,
   input  logic [7:0]    a_data,
   input  logic          a_we,
   output logic [7:0]    a_q,
   // command handshake
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   // load stream
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_data,
   // flush stream
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic [HW-1:0] out_head,
   output logic [SW-1:0] out_sector,
   output logic          out_last,
   // status
   output logic          busy,
   output logic          dirty_any
);

   localparam int                IW          = HW + SW;
   localparam int                NSEC        = HEADS * SECTORS;
   localparam logic [BYTE_W-1:0] c_last_byte = BYTE_W'(SEC_BYTES - 1);
   localparam logic [BYTE_W:0]   c_sec_limit = (BYTE_W + 1)'(SEC_BYTES);
   localparam logic [IW-1:0]     c_last_idx  = IW'(NSEC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SCAN   = 2'd2,
      ST_STREAM = 2'd3
   } state_t;

   logic [7:0]        mem_q [0:(2**AW)-1];
   state_t            state_q;
   logic [IW-1:0]     idx_q;
   logic [BYTE_W-1:0] byte_q;
   logic [NSEC-1:0]   dirty_q;
   logic [NSEC-1:0]   dirty_d;
   logic              dirty_any_q;
   logic              cmd_ready_q;
   logic              in_ready_q;
   logic              busy_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              redirty_q;
   logic [7:0]        rd_data_q;
   logic [7:0]        out_data_q;
   logic [HW-1:0]     out_head_q;
   logic [SW-1:0]     out_sector_q;

   logic [IW-1:0]     w_a_idx;
   logic [BYTE_W-1:0] w_a_off;
   logic              w_a_wr;
   logic              w_a_set;
   logic              w_hit;
   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_load_done;
   logic              w_clr;
   logic [BYTE_W-1:0] w_byte_nx;

   assign w_a_idx     = a_addr[AW-1:BYTE_W];
   assign w_a_off     = a_addr[BYTE_W-1:0];
   // Drive writes are dropped while a cylinder is being loaded.
   assign w_a_wr      = a_we && (state_q != ST_LOAD);
   assign w_a_set     = w_a_wr && ({1'b0, w_a_off} < c_sec_limit);
   assign w_hit       = w_a_set && (w_a_idx == idx_q);
   assign w_in_fire   = in_valid && in_ready_q;
   assign w_out_fire  = out_valid_q && out_ready;
   assign w_load_done = w_in_fire && (byte_q == c_last_byte) && (idx_q == c_last_idx);
   // A sector touched by the drive while it was streaming stays dirty.
   assign w_clr       = (state_q == ST_STREAM) && w_out_fire && out_last_q && !redirty_q;
   assign w_byte_nx   = byte_q + 1'b1;

   assign a_q        = rd_data_q;
   assign cmd_ready  = cmd_ready_q;
   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_head   = out_head_q;
   assign out_sector = out_sector_q;
   assign out_last   = out_last_q;
   assign busy       = busy_q;
   assign dirty_any  = dirty_any_q;

   // Single write port: the engine owns it during LOAD, the drive otherwise.
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         mem_q[{idx_q, byte_q}] <= in_data;
      end else if (w_a_wr) begin
         mem_q[a_addr] <= a_data;
      end
   end

   // Drive read port, write-first so a write echoes the new byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= 8'h00;
      end else if (w_a_wr) begin
         rd_data_q <= a_data;
      end else begin
         rd_data_q <= mem_q[a_addr];
      end
   end

   // Dirty bitmap next state: a drive write always wins over any clear.
   always_comb begin
      dirty_d = dirty_q;
      if (w_load_done) begin
         dirty_d = '0;
      end
      if (w_clr) begin
         dirty_d[idx_q] = 1'b0;
      end
      if (w_a_set) begin
         dirty_d[w_a_idx] = 1'b1;
      end
   end

   // Dirty bitmap and its summary flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dirty_q     <= '0;
         dirty_any_q <= 1'b0;
      end else begin
         dirty_q     <= dirty_d;
         dirty_any_q <= |dirty_d;
      end
   end

   // Engine FSM with registered handshake, status and stream outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         byte_q       <= '0;
         cmd_ready_q  <= 1'b1;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         redirty_q    <= 1'b0;
         out_data_q   <= 8'h00;
         out_head_q   <= '0;
         out_sector_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  idx_q       <= '0;
                  byte_q      <= '0;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (cmd_op) begin
                     state_q <= ST_SCAN;
                  end else begin
                     state_q    <= ST_LOAD;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (w_in_fire) begin
                  if (byte_q == c_last_byte) begin
                     byte_q <= '0;
                     if (idx_q == c_last_idx) begin
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end else begin
                     byte_q <= w_byte_nx;
                  end
               end
            end
            ST_SCAN: begin
               if (dirty_q[idx_q]) begin
                  // Prefetch byte 0 so out_valid is up on the first STREAM cycle.
                  state_q      <= ST_STREAM;
                  byte_q       <= '0;
                  out_valid_q  <= 1'b1;
                  out_data_q   <= mem_q[{idx_q, {BYTE_W{1'b0}}}];
                  out_last_q   <= (c_last_byte == '0);
                  out_head_q   <= idx_q[IW-1:SW];
                  out_sector_q <= idx_q[SW-1:0];
                  redirty_q    <= w_hit;
               end else if (idx_q == c_last_idx) begin
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_STREAM: begin
               if (w_hit) begin
                  redirty_q <= 1'b1;
               end
               if (w_out_fire) begin
                  if (out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     if (idx_q == c_last_idx) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                     end else begin
                        state_q <= ST_SCAN;
                        idx_q   <= idx_q + 1'b1;
                     end
                  end else begin
                     // Read the following byte into the output register on acceptance.
                     byte_q     <= w_byte_nx;
                     out_data_q <= mem_q[{idx_q, w_byte_nx}];
                     out_last_q <= (w_byte_nx == c_last_byte);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
